char_write_scheduler: RTL
=========================

CHAR_WRITE_SCHEDULER -- requirements
Module: char_write_scheduler

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 11, character buffer address width.
REQ-002 SHALL have parameter BUF_SIZE, default 2000, number of cells (ROWS*COLS); addresses wrap at BUF_SIZE.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 a_addr  input  ADDR_BITS  command-path write address.
REQ-006 a_data  input  8  command-path write character.
REQ-007 a_valid  input  1  command-path write request.
REQ-008 a_ready  output  1  command-path write accepted this cycle when a_valid=1.
REQ-009 fill_start  input  ADDR_BITS  first cell of fill.
REQ-010 fill_len  input  12  number of cells to fill.
REQ-011 fill_char  input  8  fill character.
REQ-012 fill_valid  input  1  fill request.
REQ-013 fill_ready  output  1  fill request accepted this cycle when fill_valid=1.
REQ-014 fill_busy  output  1  fill in progress.
REQ-015 fill_done  output  1  one-cycle pulse marking the final fill write.
REQ-016 wen  output  1  character buffer write enable.
REQ-017 waddr  output  ADDR_BITS  character buffer write address.
REQ-018 din  output  8  character buffer write data.

Function
REQ-019 SHALL implement states IDLE and FILL; IDLE->FILL on fill handshake with effective length >0; FILL->IDLE when remaining count reaches 0.
REQ-020 fill_ready SHALL equal 1 exactly when state is IDLE; combinational.
REQ-021 On fill handshake, SHALL latch start (fill_start-BUF_SIZE if fill_start>=BUF_SIZE), fill_char, and length min(fill_len, BUF_SIZE).
REQ-022 fill_len=0 SHALL be accepted, stay IDLE, issue no writes, pulse fill_done the next cycle.
REQ-023 In IDLE, a_ready SHALL be 1; simultaneous a_valid and fill_valid SHALL both be accepted, A write issued that cycle, fill writes starting next cycle.
REQ-024 In FILL, SHALL arbitrate round-robin per cycle with 1-bit pointer: if a_valid and pointer=A, grant A; else grant a fill write; pointer toggles to the other side after each contended grant.
REQ-025 In FILL with a_valid=0, SHALL issue one fill write per cycle (no bubbles).
REQ-026 a_ready SHALL be combinational: 1 in IDLE, 1 in FILL when pointer=A, else 0.
REQ-027 Write port outputs (wen, waddr, din) SHALL be registered: granted write appears exactly 1 cycle after grant; wen=0 when no grant.
REQ-028 a_addr SHALL pass unmodified; fill address SHALL increment by 1 per fill write, BUF_SIZE-1 wrapping to 0.
REQ-029 fill_done SHALL assert in the same cycle wen carries the last fill write; fill_busy SHALL be 1 from cycle after handshake until fill_done cycle inclusive.
REQ-030 Remaining-count register SHALL be 12 bits, never underflow.
REQ-031 fill_valid during FILL SHALL be ignored (not accepted) until IDLE.

Reset
REQ-032 Reset SHALL force state IDLE, pointer=A, wen=0, waddr=0, din=0, fill_busy=0, fill_done=0, count=0.
REQ-033 Reset mid-fill SHALL abort the fill with no further writes and no fill_done pulse.

Structure
REQ-034 Shared package vt52_pkg SHALL hold ROWS, COLS, ADDR_BITS, BUF_SIZE and the IDLE/FILL state type.
REQ-035 Block SHALL be single-module; no sub-module is warranted.

Verification
REQ-036 Fill start=0,len=80,char=0x20, no A traffic -> 80 consecutive writes addr 0..79 data 0x20, fill_done on write 80, busy 81 cycles incl. handshake-to-done span.
REQ-037 Fill start=1990,len=20 -> addresses 1990..1999 then 0..9, no address >=2000.
REQ-038 Fill len=100 with a_valid held high (addr 500, data 0x41) -> alternating A/fill writes, A first; fill completes after 200 grants.
REQ-039 Same-cycle a_valid(addr 7,data 0x42) and fill_valid(len 3) in IDLE -> write 7/0x42 then three fill writes, both handshakes in cycle 0.
REQ-040 fill_len=0 then fill_len=4095 start=2047 -> no writes then done pulse; second fill clamps to 2000 writes starting at 47.
REQ-041 Reset asserted at fill write 10 of 50 -> wen=0 immediately, no fill_done, fill_ready=1 after release.

Source files
------------

// File: rtl/vt52_pkg.sv
// Shared VT52 character-buffer geometry and scheduler state encodings.
package vt52_pkg;

    localparam int unsigned ROWS      = 25;
    localparam int unsigned COLS      = 80;
    localparam int unsigned BUF_SIZE  = ROWS * COLS;
    localparam int unsigned ADDR_BITS = 11;
    localparam int unsigned LEN_BITS  = 12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

    typedef enum logic {
        PTR_A    = 1'b0,
        PTR_FILL = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/char_write_scheduler.sv
// Merges command-path character writes with block fills onto the single
// character-buffer write port; round-robin arbitration while a fill runs.
module char_write_scheduler #(
    parameter int unsigned ADDR_BITS = vt52_pkg::ADDR_BITS,
    parameter int unsigned BUF_SIZE  = vt52_pkg::BUF_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [7:0]           a_data,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_BITS-1:0] fill_start,
    input  logic [11:0]          fill_len,
    input  logic [7:0]           fill_char,
    input  logic                 fill_valid,
    output logic                 fill_ready,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic                 wen,
    output logic [ADDR_BITS-1:0] waddr,
    output logic [7:0]           din
);

    import vt52_pkg::fill_state_e;
    import vt52_pkg::ST_IDLE;
    import vt52_pkg::ST_FILL;
    import vt52_pkg::rr_ptr_e;
    import vt52_pkg::PTR_A;
    import vt52_pkg::PTR_FILL;

    localparam logic [11:0]          LEN_MAX    = 12'(BUF_SIZE);
    localparam logic [ADDR_BITS:0]   BUF_SIZE_X = (ADDR_BITS+1)'(BUF_SIZE);
    localparam logic [ADDR_BITS-1:0] ADDR_LAST  = ADDR_BITS'(BUF_SIZE - 1);

    fill_state_e          state_q, state_d;
    rr_ptr_e              ptr_q,   ptr_d;
    logic [11:0]          cnt_q,   cnt_d;
    logic [ADDR_BITS-1:0] faddr_q, faddr_d;
    logic [7:0]           fchar_q, fchar_d;
    logic                 wen_q,   wen_d;
    logic [ADDR_BITS-1:0] waddr_q, waddr_d;
    logic [7:0]           din_q,   din_d;
    logic                 done_q,  done_d;

    logic                 grant_a;
    logic                 grant_f;
    logic [ADDR_BITS:0]   start_ext;
    logic [ADDR_BITS-1:0] start_norm;
    logic [11:0]          eff_len;

    // Request normalisation: start folds back into the buffer once, length clamps to one screen.
    always_comb begin
        start_ext  = {1'b0, fill_start};
        start_norm = fill_start;
        if (start_ext >= BUF_SIZE_X) begin
            start_norm = ADDR_BITS'(start_ext - BUF_SIZE_X);
        end
        eff_len = (fill_len > LEN_MAX) ? LEN_MAX : fill_len;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        faddr_d = faddr_q;
        fchar_d = fchar_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        din_d   = din_q;
        done_d  = 1'b0;
        grant_a = 1'b0;
        grant_f = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_a = a_valid;
                if (fill_valid) begin
                    if (eff_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                        cnt_d   = eff_len;
                        faddr_d = start_norm;
                        fchar_d = fill_char;
                    end
                end
            end
            ST_FILL: begin
                // Pointer only moves when both sides actually competed this cycle.
                if (a_valid && (ptr_q == PTR_A)) begin
                    grant_a = 1'b1;
                    ptr_d   = PTR_FILL;
                end else begin
                    grant_f = 1'b1;
                    if (a_valid) begin
                        ptr_d = PTR_A;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_a) begin
            wen_d   = 1'b1;
            waddr_d = a_addr;
            din_d   = a_data;
        end

        if (grant_f) begin
            wen_d   = 1'b1;
            waddr_d = faddr_q;
            din_d   = fchar_q;
            faddr_d = (faddr_q == ADDR_LAST) ? '0 : faddr_q + 1'b1;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 12'd1;
            end
            if (cnt_q <= 12'd1) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_A;
            cnt_q   <= '0;
            faddr_q <= '0;
            fchar_q <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            faddr_q <= faddr_d;
            fchar_q <= fchar_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            done_q  <= done_d;
        end
    end

    assign fill_ready = (state_q == ST_IDLE);
    assign a_ready    = (state_q == ST_IDLE) || (ptr_q == PTR_A);
    // Busy spans the whole fill plus the cycle carrying its final write.
    assign fill_busy  = (state_q == ST_FILL) || done_q;
    assign fill_done  = done_q;
    assign wen        = wen_q;
    assign waddr      = waddr_q;
    assign din        = din_q;

endmodule
